// File: rtl/display_counter.sv
// Multi-digit up/down display counter with internal prescaler, decimal or hex digits,
// clear/load control, wrap pulse and leading-zero blanking mask for seven-segment displays.
module display_counter #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int TICK_HZ    = 10,
   parameter int NUM_DIGITS = 6,
   parameter int RADIX      = 10
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    count_down,
   input  logic                    clear,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] digits,
   output logic                    tick,
   output logic                    wrap,
   output logic [NUM_DIGITS-1:0]   blank
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
   localparam logic [3:0]    MAX_D    = 4'(RADIX - 1);

   generate
      if (DIV < 2) begin : g_bad_div
         $error("display_counter: CLK_HZ/TICK_HZ must be at least 2");
      end
      if (RADIX != 10 && RADIX != 16) begin : g_bad_radix
         $error("display_counter: RADIX must be 10 or 16");
      end
      if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
         $error("display_counter: NUM_DIGITS must be 1..8");
      end
   endgenerate

   logic [PW-1:0]           prescaler_reg;
   logic [PW-1:0]           prescaler_next;
   logic                    tick_next;
   logic                    wrap_next;
   logic [4*NUM_DIGITS-1:0] digits_next;
   logic [4*NUM_DIGITS-1:0] stepped;
   logic [4*NUM_DIGITS-1:0] load_clamped;
   logic [NUM_DIGITS-1:0]   at_edge;
   logic [NUM_DIGITS:0]     carry;

   // carry[i] = every lower digit sits at its roll-over value, so digit i moves this step
   assign carry[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         logic [3:0] cur;
         logic [3:0] lv;
         assign cur          = digits[4*gi +: 4];
         assign lv           = load_value[4*gi +: 4];
         assign at_edge[gi]  = count_down ? (cur == 4'd0) : (cur == MAX_D);
         assign carry[gi+1]  = &at_edge[gi:0];
         assign stepped[4*gi +: 4] = !carry[gi] ? cur :
                                     at_edge[gi] ? (count_down ? MAX_D : 4'd0) :
                                     (count_down ? cur - 4'd1 : cur + 4'd1);
         assign load_clamped[4*gi +: 4] = (RADIX == 10 && lv > 4'd9) ? 4'd9 : lv;

         if (gi == 0) begin : g_lsd
            assign blank[gi] = 1'b0;
         end else begin : g_upper
            assign blank[gi] = ~|digits[4*NUM_DIGITS-1:4*gi];
         end
      end
   endgenerate

   always_comb begin
      prescaler_next = prescaler_reg;
      tick_next      = 1'b0;
      wrap_next      = 1'b0;
      digits_next    = digits;
      if (clear) begin
         prescaler_next = '0;
         digits_next    = '0;
      end else begin
         if (enable) begin
            if (prescaler_reg == PRE_LAST) begin
               prescaler_next = '0;
               tick_next      = 1'b1;
            end else begin
               prescaler_next = prescaler_reg + 1'b1;
            end
         end
         if (load) begin
            digits_next = load_clamped;
         end else if (tick && enable) begin
            digits_next = stepped;
            wrap_next   = carry[NUM_DIGITS];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler_reg <= '0;
         digits        <= '0;
         tick          <= 1'b0;
         wrap          <= 1'b0;
      end else begin
         prescaler_reg <= prescaler_next;
         digits        <= digits_next;
         tick          <= tick_next;
         wrap          <= wrap_next;
      end
   end

endmodule

// File: tb/tb_display_counter.sv
// Directed bench for display_counter: decimal (and hex) instances with DIV=4, two digits.
module tb_display_counter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       enable;
   logic       count_down;
   logic       clear;
   logic       load;
   logic [7:0] load_value;
   logic [7:0] digits;
   logic       tick;
   logic       wrap;
   logic [1:0] blank;
   logic [7:0] digits16;
   logic       tick16;
   logic       wrap16;
   logic [1:0] blank16;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       clr;
      logic       ld;
      logic [7:0] lv;
      logic [7:0] exp10;
      logic [7:0] exp16;
      logic [1:0] exp_blank;
   } vec_t;

   vec_t vecs[9];

   display_counter #(.CLK_HZ(4), .TICK_HZ(1), .NUM_DIGITS(2), .RADIX(10)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .count_down(count_down),
      .clear(clear), .load(load), .load_value(load_value),
      .digits(digits), .tick(tick), .wrap(wrap), .blank(blank)
   );

   display_counter #(.CLK_HZ(4), .TICK_HZ(1), .NUM_DIGITS(2), .RADIX(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .count_down(count_down),
      .clear(clear), .load(load), .load_value(load_value),
      .digits(digits16), .tick(tick16), .wrap(wrap16), .blank(blank16)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] exp;
      logic       found;

      vecs[0] = '{1'b0, 1'b1, 8'hA7, 8'h97, 8'hA7, 2'b00};
      vecs[1] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 2'b10};
      vecs[2] = '{1'b0, 1'b1, 8'h0F, 8'h09, 8'h0F, 2'b10};
      vecs[3] = '{1'b0, 1'b1, 8'hF0, 8'h90, 8'hF0, 2'b00};
      vecs[4] = '{1'b0, 1'b1, 8'hBC, 8'h99, 8'hBC, 2'b00};
      vecs[5] = '{1'b1, 1'b1, 8'h55, 8'h00, 8'h00, 2'b10};
      vecs[6] = '{1'b0, 1'b1, 8'h30, 8'h30, 8'h30, 2'b00};
      vecs[7] = '{1'b0, 1'b1, 8'h05, 8'h05, 8'h05, 2'b10};
      vecs[8] = '{1'b0, 1'b1, 8'h42, 8'h42, 8'h42, 2'b00};

      reset_n = 1'b0; enable = 1'b0; count_down = 1'b0;
      clear = 1'b0; load = 1'b0; load_value = 8'h00;
      repeat (3) edge1();
      chk("rst_digits", digits, 8'h00);
      chk("rst_tick", tick, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_blank", blank, 2'b10);
      chk("rst_digits16", digits16, 8'h00);

      // count up from release: tick after 4 enabled edges, step on the following edge
      reset_n = 1'b1; enable = 1'b1;
      repeat (3) begin edge1(); chk("t1_tick_low", tick, 0); end
      edge1();
      chk("t1_first_tick", tick, 1);
      chk("t1_digits0", digits, 8'h00);
      for (int k = 1; k <= 10; k++) begin
         exp = 8'((k / 10) * 16 + k % 10);
         edge1();
         chk("t1_digits", digits, exp);
         chk("t1_tick_after", tick, 0);
         chk("t1_blank", blank, (k < 10) ? 2'b10 : 2'b00);
         $display("step %0d: digits=%h blank=%b", k, digits, blank);
         repeat (2) edge1();
         edge1();
         chk("t1_tick_period", tick, 1);
      end

      // load 99 on a tick edge, then wrap up
      load = 1'b1; load_value = 8'h99;
      edge1();
      load = 1'b0;
      chk("t2_load", digits, 8'h99);
      chk("t2_load_wrap", wrap, 0);
      chk("t2_load_tick", tick, 0);
      repeat (2) edge1();
      edge1();
      chk("t2_tick", tick, 1);
      edge1();
      chk("t2_wrap_digits", digits, 8'h00);
      chk("t2_wrap", wrap, 1);
      chk("t2_wrap_blank", blank, 2'b10);
      edge1();
      chk("t2_wrap_once", wrap, 0);
      edge1(); edge1();
      chk("t2_tick2", tick, 1);
      edge1();
      chk("t2_digits01", digits, 8'h01);
      chk("t2_wrap_low", wrap, 0);

      // clear, then count down through zero on both radices
      clear = 1'b1;
      edge1();
      clear = 1'b0; count_down = 1'b1;
      chk("t3_clear", digits, 8'h00);
      chk("t3_clear16", digits16, 8'h00);
      chk("t3_clear_tick", tick, 0);
      repeat (3) edge1();
      edge1();
      chk("t3_tick", tick, 1);
      edge1();
      chk("t3_down", digits, 8'h99);
      chk("t3_down_wrap", wrap, 1);
      chk("t3_down16", digits16, 8'hFF);
      chk("t3_down16_wrap", wrap16, 1);
      repeat (2) edge1();
      edge1();
      chk("t3_tick16", tick16, 1);
      edge1();
      chk("t3_down2", digits, 8'h98);
      chk("t3_down2_16", digits16, 8'hFE);
      chk("t3_down2_wrap", wrap, 0);
      count_down = 1'b0;

      // pause with prescaler at 2
      edge1();
      enable = 1'b0;
      repeat (7) begin edge1(); chk("t4_paused_tick", tick, 0); end
      chk("t4_held", digits, 8'h98);
      enable = 1'b1;
      edge1();
      chk("t4_resume1", tick, 0);
      edge1();
      chk("t4_resume2", tick, 1);
      edge1();
      chk("t4_step", digits, 8'h99);

      // clear and load together on a tick edge
      repeat (2) edge1();
      edge1();
      chk("t5_tick", tick, 1);
      clear = 1'b1; load = 1'b1; load_value = 8'h55;
      edge1();
      clear = 1'b0; load = 1'b0;
      chk("t5_clr_digits", digits, 8'h00);
      chk("t5_clr_wrap", wrap, 0);
      chk("t5_clr_tick", tick, 0);
      repeat (3) begin edge1(); chk("t5_presc_zero", tick, 0); end
      edge1();
      chk("t5_tick_after_clr", tick, 1);

      for (int i = 0; i < 9; i++) begin
         clear = vecs[i].clr; load = vecs[i].ld; load_value = vecs[i].lv;
         edge1();
         chk("vec_digits", digits, vecs[i].exp10);
         chk("vec_digits16", digits16, vecs[i].exp16);
         chk("vec_blank", blank, vecs[i].exp_blank);
         chk("vec_blank16", blank16, vecs[i].exp_blank);
         chk("vec_wrap", wrap, 0);
         $display("vec %0d: clr=%b ld=%b lv=%h digits=%h digits16=%h blank=%b",
                  i, vecs[i].clr, vecs[i].ld, vecs[i].lv, digits, digits16, blank);
      end
      clear = 1'b0; load = 1'b0;

      // asynchronous reset between edges while a tick is high
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
         edge1();
         if (tick) found = 1'b1;
      end
      chk("t6_tick_seen", found, 1);
      chk("t6_digits42", digits, 8'h42);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_async_digits", digits, 8'h00);
      chk("t6_async_tick", tick, 0);
      chk("t6_async_wrap", wrap, 0);
      chk("t6_async_blank", blank, 2'b10);
      edge1();
      reset_n = 1'b1;
      repeat (3) begin edge1(); chk("t6_rel_tick_low", tick, 0); end
      edge1();
      chk("t6_rel_tick", tick, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
